time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
Button-driven time-setting controller for the digital clock. It is the writer side of the BCD seconds/minutes counter: it takes a snapshot of the running time, lets the user edit minutes and then seconds with two buttons, and commits the edited value back with a one-cycle load strobe. It also drives a per-digit blank mask so the seven-segment driver can blink the field being edited.

Parameters:
DEBOUNCE_CYCLES, 1000000, clk cycles a synchronized button must hold a level before the debounced level changes (10 ms at 100 MHz)
BLINK_CYCLES, 25000000, clk cycles per blink half-period for the field being edited
REPEAT_CYCLES, 30000000, clk cycles between auto-repeat increments (used only with AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
btn_mode  in  1  raw mode button, asynchronous, active-high
btn_inc  in  1  raw increment button, asynchronous, active-high
secslo_in  in  4  current seconds units (BCD) from the counter
secshi_in  in  4  current seconds tens (BCD)
minslo_in  in  4  current minutes units (BCD)
minshi_in  in  4  current minutes tens (BCD)
secslo_out  out  4  edited seconds units
secshi_out  out  4  edited seconds tens
minslo_out  out  4  edited minutes units
minshi_out  out  4  edited minutes tens
load  out  1  one-cycle pulse; the counter replaces its value with the *_out values
set_active  out  1  high in any editing state; the counter must hold (not count) while it is high
blank_mask  out  4  bit 3 = minshi, bit 2 = minslo, bit 1 = secshi, bit 0 = secslo; 1 = blank that digit

Behaviour:
- Reset (reset = 0, asynchronous): state goes to RUN. All *_out, load, set_active, blank_mask, debouncer, blink and repeat counters go to 0.
- Button input path:
  - Each button passes through a 2-flop synchronizer.
  - The debouncer counter clears whenever the synchronized level equals the debounced level. The debounced level flips once the levels have differed for DEBOUNCE_CYCLES consecutive cycles.
  - A press is a one-cycle pulse on the debounced rising edge.
  - Press latency from a raw edge = 2 + DEBOUNCE_CYCLES cycles, ±1.
- FSM states and transitions:
  - RUN: set_active = 0, blank_mask = 0. On a mode press, capture all four *_in values into the *_out registers and go to SET_MIN. Inc presses are ignored.
  - SET_MIN: set_active = 1. An inc press increments minutes. A mode press goes to SET_SEC.
  - SET_SEC: set_active = 1. An inc press increments seconds. A mode press goes to COMMIT.
  - COMMIT: load = 1 for exactly this one cycle, set_active = 1. Next state is RUN unconditionally. The *_out values are held afterwards.
- Simultaneous mode and inc presses in the same cycle: mode wins and the inc press is discarded.
- BCD increment of a field {hi, lo}:
  - If hi > 5 or lo > 9 (invalid captured value): result 00.
  - Else if hi = 5 and lo = 9: result 00 (wrap).
  - Else if lo = 9: result {hi+1, 0}.
  - Else: result {hi, lo+1}.
  - Each increment takes effect the cycle after the press pulse.
  - Captured values are not validated until they are incremented.
- Blink:
  - The blink counter runs only in SET_MIN and SET_SEC and toggles a phase bit every BLINK_CYCLES.
  - The counter and phase clear on every state change, so a new field starts visible.
  - SET_MIN: blank_mask = {phase, phase, 0, 0}.
  - SET_SEC: blank_mask = {0, 0, phase, phase}.
  - RUN and COMMIT: blank_mask = 0.
- Reset mid-edit: the edit is abandoned, no load is issued, and all outputs go to their reset values.
- Outputs are registered. No combinational path runs from any input to any output.

Optional Feature:
AUTO_REPEAT_EN
- Defined: in SET_MIN or SET_SEC, while debounced inc stays high, one additional increment fires every REPEAT_CYCLES after the initial press. The repeat counter clears on inc release and on any state change.
- Undefined: no repeat counter is built; one press gives exactly one increment.

Test Plan:
- Bench overrides: DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, REPEAT_CYCLES=6.
- Reset, then hold inputs at 12:34 with no buttons pressed -> load never pulses, set_active=0, all *_out=0, blank_mask=0.
- Inputs 12:34; mode, inc ×3, mode, inc ×2, mode -> exactly one load pulse with minutes 15, seconds 36; set_active drops to 0 the cycle after load.
- Inputs 59:59; mode, inc, mode, inc, mode -> load with 00:00. Inputs 09:09; one inc in each field -> 10:10.
- Glitch on btn_mode shorter than 4 cycles -> no state change. mode and inc pressed in the same cycle while in SET_MIN -> state goes to SET_SEC and minutes are unchanged.
- In SET_MIN, hold with no presses for 32 cycles -> blank_mask alternates 1100 and 0000 every 8 cycles. After a mode press -> the pattern moves to 0011, starting with 0000.
- Assert reset in SET_SEC with edited value 15:36 -> no load pulse, state RUN, outputs all 0. With AUTO_REPEAT_EN defined, hold inc for 20 cycles in SET_SEC starting from 00 -> seconds reach 03.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: snapshots the running time, edits minutes then seconds,
// and commits with a one-cycle load strobe. Optional auto-repeat on held inc: `define AUTO_REPEAT_EN.
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int BLINK_CYCLES    = 25000000,
   parameter int REPEAT_CYCLES   = 30000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] secslo_in,
   input  logic [3:0] secshi_in,
   input  logic [3:0] minslo_in,
   input  logic [3:0] minshi_in,
   output logic [3:0] secslo_out,
   output logic [3:0] secshi_out,
   output logic [3:0] minslo_out,
   output logic [3:0] minshi_out,
   output logic       load,
   output logic       set_active,
   output logic [3:0] blank_mask
);

   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int BKW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC, COMMIT} state_t;

   state_t     state_reg, state_next;
   logic [1:0] raw_btn;
   logic [1:0] press;
   logic       mode_press, inc_press, inc_fire, rep_fire;
   logic       capture, inc_min, inc_sec, editing;

   assign raw_btn    = {btn_inc, btn_mode};
   assign mode_press = press[0];
   assign inc_press  = press[1];

   // Per-button synchronizer + debouncer; press is high during the first debounced-high cycle.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : btn_gen
         logic           sync1_reg, sync2_reg, deb_reg, press_reg;
         logic [DBW-1:0] cnt_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               press_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= raw_btn[gi];
               sync2_reg <= sync1_reg;
               press_reg <= 1'b0;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == DBW'(DEBOUNCE_CYCLES - 1)) begin
                  cnt_reg   <= '0;
                  deb_reg   <= sync2_reg;
                  press_reg <= sync2_reg;
               end else begin
                  cnt_reg <= cnt_reg + DBW'(1);
               end
            end
         end

         assign press[gi] = press_reg;
      end
   endgenerate

   assign editing = (state_reg == SET_MIN) || (state_reg == SET_SEC);

`ifdef AUTO_REPEAT_EN
   localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   logic           inc_deb;
   logic [RPW-1:0] rep_cnt_reg;

   assign inc_deb  = btn_gen[1].deb_reg;
   assign rep_fire = editing && inc_deb && (rep_cnt_reg == RPW'(REPEAT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rep_cnt_reg <= '0;
      end else if (!editing || !inc_deb || (state_next != state_reg) || rep_fire) begin
         rep_cnt_reg <= '0;
      end else begin
         rep_cnt_reg <= rep_cnt_reg + RPW'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   assign inc_fire = inc_press | rep_fire;

   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      inc_min    = 1'b0;
      inc_sec    = 1'b0;
      case (state_reg)
         RUN: begin
            if (mode_press) begin
               state_next = SET_MIN;
               capture    = 1'b1;
            end
         end
         SET_MIN: begin
            if (mode_press)    state_next = SET_SEC;
            else if (inc_fire) inc_min    = 1'b1;
         end
         SET_SEC: begin
            if (mode_press)    state_next = COMMIT;
            else if (inc_fire) inc_sec    = 1'b1;
         end
         default: state_next = RUN;
      endcase
   end

   // Blink timing restarts on every state change so a freshly selected field starts visible.
   logic [BKW-1:0] blink_cnt_reg, blink_cnt_next;
   logic           phase_reg, phase_next;
   logic [3:0]     mask_next;

   always_comb begin
      blink_cnt_next = '0;
      phase_next     = 1'b0;
      if (state_next == state_reg && editing) begin
         if (blink_cnt_reg == BKW'(BLINK_CYCLES - 1)) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + BKW'(1);
            phase_next     = phase_reg;
         end
      end
      case (state_next)
         SET_MIN: mask_next = {phase_next, phase_next, 2'b00};
         SET_SEC: mask_next = {2'b00, phase_next, phase_next};
         default: mask_next = 4'b0000;
      endcase
   end

   function automatic logic [7:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo);
      if (hi > 4'd5 || lo > 4'd9)      return 8'h00;
      else if (hi == 4'd5 && lo == 4'd9) return 8'h00;
      else if (lo == 4'd9)             return {hi + 4'd1, 4'd0};
      else                             return {hi, lo + 4'd1};
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= RUN;
         blink_cnt_reg <= '0;
         phase_reg     <= 1'b0;
         load          <= 1'b0;
         set_active    <= 1'b0;
         blank_mask    <= 4'b0000;
         secslo_out    <= 4'd0;
         secshi_out    <= 4'd0;
         minslo_out    <= 4'd0;
         minshi_out    <= 4'd0;
      end else begin
         state_reg     <= state_next;
         blink_cnt_reg <= blink_cnt_next;
         phase_reg     <= phase_next;
         load          <= (state_next == COMMIT);
         set_active    <= (state_next != RUN);
         blank_mask    <= mask_next;
         if (capture) begin
            secslo_out <= secslo_in;
            secshi_out <= secshi_in;
            minslo_out <= minslo_in;
            minshi_out <= minshi_in;
         end else if (inc_min) begin
            {minshi_out, minslo_out} <= bcd_inc(minshi_out, minslo_out);
         end else if (inc_sec) begin
            {secshi_out, secslo_out} <= bcd_inc(secshi_out, secslo_out);
         end
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short debounce/blink/repeat periods.
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_mode, btn_inc;
   logic [3:0] secslo_in, secshi_in, minslo_in, minshi_in;
   logic [3:0] secslo_out, secshi_out, minslo_out, minshi_out;
   logic       load, set_active;
   logic [3:0] blank_mask;
   logic [15:0] outs;

   int total = 0;
   int bad   = 0;
   int load_cnt = 0;
   logic [15:0] load_val = '0;
   logic sa_at_load = 1'b0, sa_after = 1'b1, load_prev = 1'b0;

   time_set_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8), .REPEAT_CYCLES(6)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .secslo_in(secslo_in), .secshi_in(secshi_in), .minslo_in(minslo_in), .minshi_in(minshi_in),
      .secslo_out(secslo_out), .secshi_out(secshi_out), .minslo_out(minslo_out), .minshi_out(minshi_out),
      .load(load), .set_active(set_active), .blank_mask(blank_mask)
   );

   always #5 clk = ~clk;

   assign outs = {minshi_out, minslo_out, secshi_out, secslo_out};

   // Load monitor: counts pulses and records the committed value and set_active around them.
   always @(negedge clk) begin
      if (load_prev) sa_after = set_active;
      load_prev = load;
      if (load) begin
         load_cnt++;
         load_val   = outs;
         sa_at_load = set_active;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_in(input logic [15:0] v);
      {minshi_in, minslo_in, secshi_in, secslo_in} = v;
   endtask

   task automatic press(input bit is_inc);
      if (is_inc) btn_inc = 1'b1; else btn_mode = 1'b1;
      repeat (5) @(negedge clk);
      btn_inc  = 1'b0;
      btn_mode = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic edit_cycle(input logic [15:0] v, input int nmin, input int nsec);
      set_in(v);
      press(0);
      for (int i = 0; i < nmin; i++) press(1);
      press(0);
      for (int i = 0; i < nsec; i++) press(1);
      press(0);
   endtask

   initial begin
      int n;
      reset = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
      set_in(16'h1234);
      repeat (3) @(negedge clk);
      chk("rst_outs", 32'(outs), 32'h0);
      chk("rst_sa", 32'(set_active), 32'h0);
      chk("rst_blank", 32'(blank_mask), 32'h0);
      chk("rst_load", 32'(load), 32'h0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_loads", 32'(load_cnt), 32'd0);
      chk("idle_sa", 32'(set_active), 32'h0);
      chk("idle_outs", 32'(outs), 32'h0);
      chk("idle_blank", 32'(blank_mask), 32'h0);

      // 12:34 -> 15:36
      press(0);
      chk("cap_sa", 32'(set_active), 32'h1);
      chk("cap_val", 32'(outs), 32'h1234);
      repeat (3) press(1);
      chk("min_inc", 32'(outs), 32'h1534);
      press(0);
      repeat (2) press(1);
      chk("sec_inc", 32'(outs), 32'h1536);
      chk("no_load_yet", 32'(load_cnt), 32'd0);
      press(0);
      chk("commit_cnt", 32'(load_cnt), 32'd1);
      chk("commit_val", 32'(load_val), 32'h1536);
      chk("commit_sa", 32'(sa_at_load), 32'h1);
      chk("sa_after_load", 32'(sa_after), 32'h0);
      chk("held_val", 32'(outs), 32'h1536);
      chk("run_blank", 32'(blank_mask), 32'h0);

      edit_cycle(16'h5959, 1, 1);
      chk("wrap_cnt", 32'(load_cnt), 32'd2);
      chk("wrap_val", 32'(load_val), 32'h0000);
      edit_cycle(16'h0909, 1, 1);
      chk("carry_cnt", 32'(load_cnt), 32'd3);
      chk("carry_val", 32'(load_val), 32'h1010);

      // invalid captured minutes are kept until incremented
      set_in(16'h7A34);
      press(0);
      chk("invalid_cap", 32'(outs), 32'h7A34);
      press(1);
      chk("invalid_inc", 32'(outs), 32'h0034);
      press(0);
      press(0);
      chk("invalid_cnt", 32'(load_cnt), 32'd4);
      chk("invalid_val", 32'(load_val), 32'h0034);

      // glitch and simultaneous presses
      set_in(16'h1234);
      press(0);
      btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      btn_mode = 1'b0;
      repeat (10) @(negedge clk);
      chk("glitch_sa", 32'(set_active), 32'h1);
      press(1);
      chk("glitch_min", 32'(outs), 32'h1334);
      btn_mode = 1'b1; btn_inc = 1'b1;
      repeat (5) @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (10) @(negedge clk);
      chk("both_val", 32'(outs), 32'h1334);
      press(1);
      chk("both_sec", 32'(outs), 32'h1335);
      press(0);
      chk("both_cnt", 32'(load_cnt), 32'd5);
      chk("both_load", 32'(load_val), 32'h1335);

      // blink in SET_MIN, then SET_SEC
      btn_mode = 1'b1;
      n = 0;
      while (set_active !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      btn_mode = 1'b0;
      chk("enter_min", 32'(set_active), 32'h1);
      for (int i = 0; i < 41; i++) begin
         chk("blink_min", 32'(blank_mask), ((i / 8) % 2) ? 32'hC : 32'h0);
         if (i < 40) @(negedge clk);
      end
      btn_mode = 1'b1;
      n = 0;
      while (blank_mask === 4'hC && n < 20) begin @(negedge clk); n++; end
      btn_mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("blink_sec", 32'(blank_mask), (i < 8) ? 32'h0 : 32'h3);
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      press(0);
      chk("blink_cnt", 32'(load_cnt), 32'd6);
      chk("blink_load", 32'(load_val), 32'h1234);

      // reset mid-edit
      set_in(16'h1234);
      press(0);
      repeat (3) press(1);
      press(0);
      repeat (2) press(1);
      chk("pre_rst_val", 32'(outs), 32'h1536);
      chk("pre_rst_sa", 32'(set_active), 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_rst_outs", 32'(outs), 32'h0);
      chk("mid_rst_sa", 32'(set_active), 32'h0);
      chk("mid_rst_blank", 32'(blank_mask), 32'h0);
      chk("mid_rst_load", 32'(load), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_cnt", 32'(load_cnt), 32'd6);
      chk("post_rst_sa", 32'(set_active), 32'h0);
      press(0);
      chk("post_rst_cap", 32'(outs), 32'h1234);
      press(0);
      press(0);
      chk("post_rst_commit", 32'(load_cnt), 32'd7);

`ifdef AUTO_REPEAT_EN
      set_in(16'h0000);
      press(0);
      press(0);
      btn_inc = 1'b1;
      repeat (20) @(negedge clk);
      btn_inc = 1'b0;
      repeat (12) @(negedge clk);
      chk("repeat_sec", 32'(secslo_out >= 4'd3 && secshi_out == 4'd0), 32'h1);
      press(0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
